temporal_ngram_encoder: RTL and testbench



---
 rtl/temporal_ngram_encoder_if.sv | 26 ++
 rtl/temporal_ngram_encoder.sv | 88 ++++++++
 tb/tb_temporal_ngram_encoder.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/temporal_ngram_encoder_if.sv
// rtl/temporal_ngram_encoder_if.sv - input/output hypervector handshake bundle
`ifndef HV_DIMENSION
`define HV_DIMENSION 2000
`endif

interface temporal_ngram_encoder_if #(
  parameter int HV_DIMENSION = `HV_DIMENSION
);
  logic                     ValidIn_SI;
  logic                     ReadyOut_SO;
  logic [0:HV_DIMENSION-1]  HypervectorIn_DI;
  logic                     Clear_SI;
  logic                     ValidOut_SO;
  logic                     ReadyIn_SI;
  logic [0:HV_DIMENSION-1]  HypervectorOut_DO;

  modport master (
    output ValidIn_SI, HypervectorIn_DI, Clear_SI, ReadyIn_SI,
    input  ReadyOut_SO, ValidOut_SO, HypervectorOut_DO
  );

  modport slave (
    input  ValidIn_SI, HypervectorIn_DI, Clear_SI, ReadyIn_SI,
    output ReadyOut_SO, ValidOut_SO, HypervectorOut_DO
  );
endinterface

// File: rtl/temporal_ngram_encoder.sv
// rtl/temporal_ngram_encoder.sv - sliding-window N-gram binding of spatial hypervectors
`ifndef HV_DIMENSION
`define HV_DIMENSION 2000
`endif

module temporal_ngram_encoder #(
  parameter int HV_DIMENSION = `HV_DIMENSION,
  parameter int NGRAM_SIZE   = 3
) (
  input  logic                    Clk_CI,
  input  logic                    Reset_RI,
  temporal_ngram_encoder_if.slave bus
);
  localparam int HN = (NGRAM_SIZE > 1) ? NGRAM_SIZE - 1 : 1;
  localparam int FW = $clog2(NGRAM_SIZE) + 1;
  localparam logic [FW-1:0] FILL_LAST = FW'(NGRAM_SIZE - 1);

  typedef logic [0:HV_DIMENSION-1] hv_t;
  typedef enum logic {WARMUP, STREAM} state_t;

  localparam state_t START_STATE = (NGRAM_SIZE == 1) ? STREAM : WARMUP;

  state_t        state;
  logic [FW-1:0] fill;
  logic [FW-1:0] fill_base;
  logic [FW-1:0] fill_next;
  hv_t           hist [HN];
  hv_t           hist_eff [HN];
  hv_t           fold;
  hv_t           ngram;
  hv_t           out_q;
  logic          valid_q;
  logic          accept;
  logic          handshake;
  logic          stream_now;

  function automatic hv_t rho(input hv_t x);
    return {x[HV_DIMENSION-1], x[0:HV_DIMENSION-2]};
  endfunction

  assign bus.ReadyOut_SO       = !Reset_RI && (!valid_q || bus.ReadyIn_SI);
  assign bus.ValidOut_SO       = valid_q;
  assign bus.HypervectorOut_DO = out_q;

  assign accept     = bus.ValidIn_SI && bus.ReadyOut_SO;
  assign handshake  = valid_q && bus.ReadyIn_SI;
  assign fill_base  = bus.Clear_SI ? '0 : fill;
  assign fill_next  = fill_base + FW'(1);
  assign stream_now = bus.Clear_SI ? (NGRAM_SIZE == 1) : (state == STREAM);

  // hist[0] is the newest vector; Horner-style folding applies one rotation per age step
  always_comb begin
    fold = '0;
    for (int i = 0; i < HN; i++) hist_eff[i] = bus.Clear_SI ? '0 : hist[i];
    for (int i = NGRAM_SIZE - 2; i >= 0; i--) fold = rho(hist_eff[i] ^ fold);
    ngram = bus.HypervectorIn_DI ^ fold;
  end

  always_ff @(posedge Clk_CI) begin
    if (Reset_RI) begin
      state   <= START_STATE;
      fill    <= '0;
      valid_q <= 1'b0;
      out_q   <= '0;
      for (int i = 0; i < HN; i++) hist[i] <= '0;
    end else begin
      if (handshake) valid_q <= 1'b0;
      if (bus.Clear_SI) begin
        state <= START_STATE;
        fill  <= '0;
        for (int i = 0; i < HN; i++) hist[i] <= '0;
      end
      if (accept) begin
        if (NGRAM_SIZE > 1) begin
          hist[0] <= bus.HypervectorIn_DI;
          for (int i = 1; i < HN; i++) hist[i] <= hist_eff[i-1];
        end
        if (stream_now) begin
          valid_q <= 1'b1;
          out_q   <= ngram;
        end else begin
          fill <= fill_next;
          if (fill_next == FILL_LAST) state <= STREAM;
        end
      end
    end
  end
endmodule

// File: tb/tb_temporal_ngram_encoder.sv
// tb/tb_temporal_ngram_encoder.sv - self-checking bench for temporal_ngram_encoder
module tb_temporal_ngram_encoder;
  localparam int DS = 8;
  localparam int DL = 2000;

  logic clk = 1'b0;
  logic rst_a, rst_b, rst_r;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  temporal_ngram_encoder_if #(.HV_DIMENSION(DS)) bus_a (), bus_b ();
  temporal_ngram_encoder_if #(.HV_DIMENSION(DL)) bus_2 (), bus_3 (), bus_5 ();

  temporal_ngram_encoder #(.HV_DIMENSION(DS), .NGRAM_SIZE(3)) dut_a (.Clk_CI(clk), .Reset_RI(rst_a), .bus(bus_a.slave));
  temporal_ngram_encoder #(.HV_DIMENSION(DS), .NGRAM_SIZE(1)) dut_b (.Clk_CI(clk), .Reset_RI(rst_b), .bus(bus_b.slave));
  temporal_ngram_encoder #(.HV_DIMENSION(DL), .NGRAM_SIZE(2)) dut_2 (.Clk_CI(clk), .Reset_RI(rst_r), .bus(bus_2.slave));
  temporal_ngram_encoder #(.HV_DIMENSION(DL), .NGRAM_SIZE(3)) dut_3 (.Clk_CI(clk), .Reset_RI(rst_r), .bus(bus_3.slave));
  temporal_ngram_encoder #(.HV_DIMENSION(DL), .NGRAM_SIZE(5)) dut_5 (.Clk_CI(clk), .Reset_RI(rst_r), .bus(bus_5.slave));

  // reference state for the wide random regression (window of accepted vectors since clear)
  logic [0:DL-1] q [3][$];
  logic          mvo [3];
  logic [0:DL-1] mout [3];
  int            nn [3] = '{2, 3, 5};

  function automatic logic [0:DL-1] rotn(input logic [0:DL-1] x, input int n);
    logic [0:DL-1] y;
    for (int k = 0; k < DL; k++) y[k] = x[(k - n + DL) % DL];
    return y;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_a(input logic v, input logic [0:DS-1] d, input logic c, input logic r);
    bus_a.ValidIn_SI = v;
    bus_a.HypervectorIn_DI = d;
    bus_a.Clear_SI = c;
    bus_a.ReadyIn_SI = r;
  endtask

  task automatic test_reset();
    rst_a = 1'b1; rst_b = 1'b1; rst_r = 1'b1;
    drive_a(1'b0, 8'h00, 1'b0, 1'b1);
    bus_b.ValidIn_SI = 1'b0; bus_b.HypervectorIn_DI = '0; bus_b.Clear_SI = 1'b0; bus_b.ReadyIn_SI = 1'b1;
    bus_2.ValidIn_SI = 1'b0; bus_2.HypervectorIn_DI = '0; bus_2.Clear_SI = 1'b0; bus_2.ReadyIn_SI = 1'b0;
    bus_3.ValidIn_SI = 1'b0; bus_3.HypervectorIn_DI = '0; bus_3.Clear_SI = 1'b0; bus_3.ReadyIn_SI = 1'b0;
    bus_5.ValidIn_SI = 1'b0; bus_5.HypervectorIn_DI = '0; bus_5.Clear_SI = 1'b0; bus_5.ReadyIn_SI = 1'b0;
    tick(); tick();
    total++; if (bus_a.ReadyOut_SO !== 1'b0) begin bad++; $display("FAIL reset_ready got=%b exp=0", bus_a.ReadyOut_SO); end
    total++; if (bus_a.ValidOut_SO !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", bus_a.ValidOut_SO); end
    total++; if (bus_a.HypervectorOut_DO !== 8'h00) begin bad++; $display("FAIL reset_data got=%b exp=00000000", bus_a.HypervectorOut_DO); end
    total++; if (bus_b.ValidOut_SO !== 1'b0) begin bad++; $display("FAIL reset_valid_n1 got=%b exp=0", bus_b.ValidOut_SO); end
    rst_a = 1'b0; rst_b = 1'b0; rst_r = 1'b0;
    #1;
    total++; if (bus_a.ReadyOut_SO !== 1'b1) begin bad++; $display("FAIL ready_after_reset got=%b exp=1", bus_a.ReadyOut_SO); end
    tick();
  endtask

  task automatic test_basic();
    drive_a(1'b1, 8'b1000_0000, 1'b0, 1'b1); tick();
    total++; if (bus_a.ValidOut_SO !== 1'b0) begin bad++; $display("FAIL basic_warm_A valid=%b exp=0", bus_a.ValidOut_SO); end
    drive_a(1'b1, 8'h00, 1'b0, 1'b1); tick();
    total++; if (bus_a.ValidOut_SO !== 1'b0) begin bad++; $display("FAIL basic_warm_B valid=%b exp=0", bus_a.ValidOut_SO); end
    drive_a(1'b1, 8'h00, 1'b0, 1'b1); tick();
    total++; if (bus_a.ValidOut_SO !== 1'b1 || bus_a.HypervectorOut_DO !== 8'b0010_0000) begin
      bad++; $display("FAIL basic_C valid=%b got=%b exp=00100000", bus_a.ValidOut_SO, bus_a.HypervectorOut_DO); end
    drive_a(1'b1, 8'b0000_0001, 1'b0, 1'b1); tick();
    total++; if (bus_a.ValidOut_SO !== 1'b1 || bus_a.HypervectorOut_DO !== 8'b0000_0001) begin
      bad++; $display("FAIL basic_D valid=%b got=%b exp=00000001", bus_a.ValidOut_SO, bus_a.HypervectorOut_DO); end
    drive_a(1'b1, 8'b0000_0001, 1'b1, 1'b1); tick();
    total++; if (bus_a.ValidOut_SO !== 1'b0) begin bad++; $display("FAIL wrap_A valid=%b exp=0", bus_a.ValidOut_SO); end
    drive_a(1'b1, 8'h00, 1'b0, 1'b1); tick();
    total++; if (bus_a.ValidOut_SO !== 1'b0) begin bad++; $display("FAIL wrap_B valid=%b exp=0", bus_a.ValidOut_SO); end
    drive_a(1'b1, 8'h00, 1'b0, 1'b1); tick();
    total++; if (bus_a.ValidOut_SO !== 1'b1 || bus_a.HypervectorOut_DO !== 8'b0100_0000) begin
      bad++; $display("FAIL wrap_C valid=%b got=%b exp=01000000", bus_a.ValidOut_SO, bus_a.HypervectorOut_DO); end
  endtask

  task automatic test_backpressure();
    drive_a(1'b1, 8'h5A, 1'b0, 1'b0); #1;
    total++; if (bus_a.ReadyOut_SO !== 1'b0) begin bad++; $display("FAIL bp_ready_low got=%b exp=0", bus_a.ReadyOut_SO); end
    for (int i = 0; i < 3; i++) begin
      tick();
      total++; if (bus_a.ValidOut_SO !== 1'b1 || bus_a.HypervectorOut_DO !== 8'b0100_0000) begin
        bad++; $display("FAIL bp_hold cycle=%0d valid=%b got=%b exp=01000000", i, bus_a.ValidOut_SO, bus_a.HypervectorOut_DO); end
      total++; if (bus_a.ReadyOut_SO !== 1'b0) begin bad++; $display("FAIL bp_ready_stall cycle=%0d got=%b exp=0", i, bus_a.ReadyOut_SO); end
    end
    bus_a.ReadyIn_SI = 1'b1; #1;
    total++; if (bus_a.ReadyOut_SO !== 1'b1) begin bad++; $display("FAIL bp_ready_high got=%b exp=1", bus_a.ReadyOut_SO); end
    tick();
    total++; if (bus_a.ValidOut_SO !== 1'b1 || bus_a.HypervectorOut_DO !== 8'h5A) begin
      bad++; $display("FAIL bp_first valid=%b got=%h exp=5a", bus_a.ValidOut_SO, bus_a.HypervectorOut_DO); end
    drive_a(1'b1, 8'h3C, 1'b0, 1'b1); tick();
    total++; if (bus_a.ValidOut_SO !== 1'b1 || bus_a.HypervectorOut_DO !== 8'h11) begin
      bad++; $display("FAIL bp_second valid=%b got=%h exp=11", bus_a.ValidOut_SO, bus_a.HypervectorOut_DO); end
  endtask

  task automatic test_clear();
    drive_a(1'b0, 8'h00, 1'b1, 1'b0); tick();
    bus_a.Clear_SI = 1'b0;
    total++; if (bus_a.ValidOut_SO !== 1'b1 || bus_a.HypervectorOut_DO !== 8'h11) begin
      bad++; $display("FAIL clear_keeps_pending valid=%b got=%h exp=11", bus_a.ValidOut_SO, bus_a.HypervectorOut_DO); end
    drive_a(1'b1, 8'hC3, 1'b0, 1'b1); tick();
    total++; if (bus_a.ValidOut_SO !== 1'b0) begin bad++; $display("FAIL clear_refill_P valid=%b exp=0", bus_a.ValidOut_SO); end
    drive_a(1'b1, 8'h99, 1'b0, 1'b1); tick();
    total++; if (bus_a.ValidOut_SO !== 1'b0) begin bad++; $display("FAIL clear_refill_Q valid=%b exp=0", bus_a.ValidOut_SO); end
    drive_a(1'b1, 8'h24, 1'b0, 1'b1); tick();
    total++; if (bus_a.ValidOut_SO !== 1'b1 || bus_a.HypervectorOut_DO !== 8'h18) begin
      bad++; $display("FAIL clear_refill_R valid=%b got=%h exp=18", bus_a.ValidOut_SO, bus_a.HypervectorOut_DO); end
    drive_a(1'b1, 8'hFF, 1'b1, 1'b1); tick();
    total++; if (bus_a.ValidOut_SO !== 1'b0) begin bad++; $display("FAIL clear_E valid=%b exp=0", bus_a.ValidOut_SO); end
    drive_a(1'b1, 8'h0F, 1'b0, 1'b1); tick();
    total++; if (bus_a.ValidOut_SO !== 1'b0) begin bad++; $display("FAIL clear_F valid=%b exp=0", bus_a.ValidOut_SO); end
    drive_a(1'b1, 8'h81, 1'b0, 1'b1); tick();
    total++; if (bus_a.ValidOut_SO !== 1'b1 || bus_a.HypervectorOut_DO !== 8'hF9) begin
      bad++; $display("FAIL clear_G valid=%b got=%h exp=f9", bus_a.ValidOut_SO, bus_a.HypervectorOut_DO); end
  endtask

  task automatic test_reset_mid();
    drive_a(1'b0, 8'h00, 1'b0, 1'b0);
    rst_a = 1'b1; #1;
    total++; if (bus_a.ReadyOut_SO !== 1'b0) begin bad++; $display("FAIL rmid_ready got=%b exp=0", bus_a.ReadyOut_SO); end
    tick();
    rst_a = 1'b0;
    total++; if (bus_a.ValidOut_SO !== 1'b0 || bus_a.HypervectorOut_DO !== 8'h00) begin
      bad++; $display("FAIL rmid_flush valid=%b got=%h exp=0/00", bus_a.ValidOut_SO, bus_a.HypervectorOut_DO); end
    drive_a(1'b1, 8'h01, 1'b0, 1'b1); tick();
    total++; if (bus_a.ValidOut_SO !== 1'b0) begin bad++; $display("FAIL rmid_warm1 valid=%b exp=0", bus_a.ValidOut_SO); end
    drive_a(1'b1, 8'h00, 1'b0, 1'b1); tick();
    total++; if (bus_a.ValidOut_SO !== 1'b0) begin bad++; $display("FAIL rmid_warm2 valid=%b exp=0", bus_a.ValidOut_SO); end
    drive_a(1'b1, 8'h00, 1'b0, 1'b1); tick();
    total++; if (bus_a.ValidOut_SO !== 1'b1 || bus_a.HypervectorOut_DO !== 8'h40) begin
      bad++; $display("FAIL rmid_first valid=%b got=%h exp=40", bus_a.ValidOut_SO, bus_a.HypervectorOut_DO); end
    drive_a(1'b0, 8'h00, 1'b0, 1'b1);
  endtask

  task automatic test_n1_passthrough();
    logic [0:DS-1] x;
    for (int i = 0; i < 20; i++) begin
      x = 8'($urandom);
      bus_b.ValidIn_SI = 1'b1;
      bus_b.HypervectorIn_DI = x;
      bus_b.Clear_SI = (i == 7);
      bus_b.ReadyIn_SI = 1'b1;
      tick();
      total++; if (bus_b.ValidOut_SO !== 1'b1 || bus_b.HypervectorOut_DO !== x) begin
        bad++; $display("FAIL n1_pass idx=%0d valid=%b got=%h exp=%h", i, bus_b.ValidOut_SO, bus_b.HypervectorOut_DO, x); end
    end
    bus_b.ValidIn_SI = 1'b0;
    bus_b.Clear_SI = 1'b0;
    tick();
    total++; if (bus_b.ValidOut_SO !== 1'b0) begin bad++; $display("FAIL n1_drain valid=%b exp=0", bus_b.ValidOut_SO); end
  endtask

  task automatic test_random();
    logic [0:DL-1] x;
    logic          v, c, r, acc;
    logic          rdy [3];
    logic          vo [3];
    logic [0:DL-1] dout [3];
    for (int m = 0; m < 3; m++) begin
      q[m].delete();
      mvo[m] = 1'b0;
      mout[m] = '0;
    end
    for (int cyc = 0; cyc < 400; cyc++) begin
      v = ($urandom_range(0, 9) < 7);
      r = ($urandom_range(0, 9) < 6);
      c = ($urandom_range(0, 15) == 0);
      for (int k = 0; k < DL; k++) x[k] = 1'($urandom_range(0, 1));
      bus_2.ValidIn_SI = v; bus_2.HypervectorIn_DI = x; bus_2.Clear_SI = c; bus_2.ReadyIn_SI = r;
      bus_3.ValidIn_SI = v; bus_3.HypervectorIn_DI = x; bus_3.Clear_SI = c; bus_3.ReadyIn_SI = r;
      bus_5.ValidIn_SI = v; bus_5.HypervectorIn_DI = x; bus_5.Clear_SI = c; bus_5.ReadyIn_SI = r;
      #1;
      rdy  = '{bus_2.ReadyOut_SO, bus_3.ReadyOut_SO, bus_5.ReadyOut_SO};
      vo   = '{bus_2.ValidOut_SO, bus_3.ValidOut_SO, bus_5.ValidOut_SO};
      dout = '{bus_2.HypervectorOut_DO, bus_3.HypervectorOut_DO, bus_5.HypervectorOut_DO};
      for (int m = 0; m < 3; m++) begin
        total++; if (vo[m] !== mvo[m]) begin
          bad++; $display("FAIL rnd_valid n=%0d cyc=%0d got=%b exp=%b", nn[m], cyc, vo[m], mvo[m]); end
        total++; if (rdy[m] !== (!mvo[m] || r)) begin
          bad++; $display("FAIL rnd_ready n=%0d cyc=%0d got=%b exp=%b", nn[m], cyc, rdy[m], (!mvo[m] || r)); end
        if (mvo[m] && r) begin
          total++; if (dout[m] !== mout[m]) begin
            bad++; $display("FAIL rnd_data n=%0d cyc=%0d got_tail=%h exp_tail=%h", nn[m], cyc, dout[m][DL-32 +: 32], mout[m][DL-32 +: 32]); end
        end
        acc = v && (!mvo[m] || r);
        if (mvo[m] && r) mvo[m] = 1'b0;
        if (c) q[m].delete();
        if (acc) begin
          q[m].push_back(x);
          if (q[m].size() > nn[m]) void'(q[m].pop_front());
          if (q[m].size() == nn[m]) begin
            mout[m] = '0;
            for (int i = 0; i < nn[m]; i++) mout[m] = mout[m] ^ rotn(q[m][nn[m] - 1 - i], i);
            mvo[m] = 1'b1;
          end
        end
      end
      tick();
    end
    bus_2.ValidIn_SI = 1'b0; bus_3.ValidIn_SI = 1'b0; bus_5.ValidIn_SI = 1'b0;
    bus_2.Clear_SI = 1'b0; bus_3.Clear_SI = 1'b0; bus_5.Clear_SI = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_clear();
    test_reset_mid();
    test_n1_passthrough();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
